// File: rtl/wb_cache_ctrl.sv
// wb_cache_ctrl: direct-mapped, write-back, write-allocate data cache with word-serial refill/writeback.
// Define CACHE_STATS_EN to add the hit_count/miss_count/wb_count statistics outputs.
module wb_cache_ctrl #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_LINES       = 4,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef CACHE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count,
`endif
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT} state_t;
  state_t state, state_nxt;

  logic                  valid [NUM_LINES];
  logic                  dirty [NUM_LINES];
  logic [TAG_W-1:0]      tag   [NUM_LINES];
  logic [DATA_WIDTH-1:0] block [NUM_LINES][WORDS_PER_BLOCK];

  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [OFF_W-1:0]      beat;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             hit;
  logic             last_beat;

  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_off   = req_addr[OFF_W-1:0];
  assign hit       = valid[req_idx] && (tag[req_idx] == req_tag);
  // Block size is a power of two, so the final beat is the all-ones count.
  assign last_beat = &beat;

  assign cpu_req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state)
      IDLE:   if (cpu_req_valid) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit)                                   state_nxt = IDLE;
        else if (valid[req_idx] && dirty[req_idx]) state_nxt = WB_REQ;
        else                                       state_nxt = RF_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag[req_idx], req_idx, beat};
        mem_req_wdata = block[req_idx][beat];
        if (mem_req_ready && last_beat) state_nxt = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, beat};
        if (mem_req_ready) state_nxt = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_resp_valid) state_nxt = last_beat ? LOOKUP : RF_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        valid[i] <= 1'b0;
        dirty[i] <= 1'b0;
        tag[i]   <= '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) block[i][w] <= '0;
      end
      beat           <= '0;
      req_write      <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_write <= cpu_req_write;
            req_addr  <= cpu_req_addr;
            req_wdata <= cpu_req_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid <= 1'b1;
            if (req_write) begin
              block[req_idx][req_off] <= req_wdata;
              dirty[req_idx]          <= 1'b1;
              cpu_resp_rdata          <= req_wdata;
            end else begin
              cpu_resp_rdata <= block[req_idx][req_off];
            end
          end else begin
            beat <= '0;
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            beat <= beat + 1'b1;
            if (last_beat) dirty[req_idx] <= 1'b0;
          end
        end
        RF_WAIT: begin
          if (mem_resp_valid) begin
            block[req_idx][beat] <= mem_resp_rdata;
            beat                 <= beat + 1'b1;
            if (last_beat) begin
              tag[req_idx]   <= req_tag;
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // refilled marks the guaranteed-hit LOOKUP after a refill so it is not counted again.
  logic refilled;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refilled   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == IDLE) refilled <= 1'b0;
      if (state == RF_WAIT && mem_resp_valid && last_beat) refilled <= 1'b1;
      if (state == LOOKUP && !refilled) begin
        if (hit) hit_count  <= hit_count + 32'd1;
        else     miss_count <= miss_count + 32'd1;
      end
      if (state == WB_REQ && mem_req_ready && last_beat) wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Randomized bench for wb_cache_ctrl against a core-view memory model with a tag/valid/dirty shadow.
module tb_wb_cache_ctrl;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int NL  = 4;
  localparam int WPB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic          cpu_req_write = 1'b0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [DW-1:0] cpu_req_wdata = '0;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count, miss_count, wb_count;
`endif

  wb_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LINES(NL), .WORDS_PER_BLOCK(WPB)) dut (
    .clock(clock), .reset(reset),
`ifdef CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] view [0:(1<<AW)-1];
  bit            rm_valid [NL];
  bit            rm_dirty [NL];
  int            rm_tag   [NL];
  int            exp_hits, exp_misses, exp_wbs;

  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log_a[$];
  logic [DW-1:0] wr_log_d[$];

  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  bit            prev_pending = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_write;
  bit            stall_arm = 0;
  bit            rand_ready = 0;
  int            stall_left = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory: acts half a cycle ahead of the edge where a beat is accepted; reads answer 2 cycles later.
  always @(negedge clock) begin
    if (reset) begin
      pend_cnt       = 0;
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      stall_left     = 0;
      stall_arm      = 0;
      prev_pending   = 0;
    end else begin
      mem_resp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = mem[pend_addr];
        end
      end
      if (prev_pending) begin
        check("hold_valid", mem_req_valid, 1);
        check("hold_addr", mem_req_addr, prev_addr);
        check("hold_write", mem_req_write, prev_write);
        if (prev_write) check("hold_wdata", mem_req_wdata, prev_wdata);
      end
      if (stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else if (stall_arm && mem_req_valid && !mem_req_write && mem_req_addr[1:0] == 2'd2) begin
        stall_arm     = 0;
        stall_left    = 4;
        mem_req_ready = 1'b0;
      end else begin
        mem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_write) begin
          wr_log_a.push_back(mem_req_addr);
          wr_log_d.push_back(mem_req_wdata);
          mem[mem_req_addr] = mem_req_wdata;
        end else begin
          rd_log.push_back(mem_req_addr);
          pend_cnt  = 2;
          pend_addr = mem_req_addr;
        end
        prev_pending = 0;
      end else begin
        prev_pending = mem_req_valid;
        prev_addr    = mem_req_addr;
        prev_wdata   = mem_req_wdata;
        prev_write   = mem_req_write;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < (1<<AW); i++) view[i] = mem[i];
    for (int i = 0; i < NL; i++) begin
      rm_valid[i] = 0;
      rm_dirty[i] = 0;
      rm_tag[i]   = 0;
    end
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    model_reset();
    #1 check("ready_after_reset", cpu_req_ready, 1);
`ifdef CACHE_STATS_EN
    check("hit_count_rst", hit_count, 0);
    check("miss_count_rst", miss_count, 0);
    check("wb_count_rst", wb_count, 0);
`endif
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int idx, tg, cyc;
    bit exp_hit, exp_wb;
    logic [AW-1:0] ea;
    logic [DW-1:0] exp_rd;
    idx     = (int'(a) / WPB) % NL;
    tg      = int'(a) / (WPB * NL);
    exp_hit = rm_valid[idx] && rm_tag[idx] == tg;
    exp_wb  = !exp_hit && rm_valid[idx] && rm_dirty[idx];
    exp_rd  = wr ? d : view[a];
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete();
    @(negedge clock);
    check("req_ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = a; cpu_req_wdata = d;
    @(negedge clock);
    cpu_req_valid = 1'b0; cpu_req_write = 1'b0;
    cpu_req_addr  = AW'($urandom); cpu_req_wdata = $urandom;
    cyc = 1;
    while (!cpu_resp_valid && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check("resp_valid", cpu_resp_valid, 1);
    if (exp_hit) check("hit_latency", cyc, 2);
    check("resp_rdata", cpu_resp_rdata, exp_rd);
    @(negedge clock);
    check("resp_pulse", cpu_resp_valid, 0);
    check("wb_beats", wr_log_a.size(), exp_wb ? WPB : 0);
    for (int b = 0; b < wr_log_a.size() && b < WPB; b++) begin
      ea = AW'(rm_tag[idx] * WPB * NL + idx * WPB + b);
      check("wb_addr", wr_log_a[b], ea);
      check("wb_data", wr_log_d[b], view[ea]);
    end
    check("rf_beats", rd_log.size(), exp_hit ? 0 : WPB);
    for (int b = 0; b < rd_log.size() && b < WPB; b++)
      check("rf_addr", rd_log[b], AW'(tg * WPB * NL + idx * WPB + b));
    if (exp_hit) exp_hits++; else exp_misses++;
    if (exp_wb) exp_wbs++;
    rm_valid[idx] = 1;
    rm_tag[idx]   = tg;
    if (!exp_hit) rm_dirty[idx] = 0;
    if (wr) begin
      view[a]       = d;
      rm_dirty[idx] = 1;
    end
`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    check("wb_count", wb_count, exp_wbs);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i);
    model_reset();
    #1;
    check("rst_cpu_req_ready", cpu_req_ready, 0);
    check("rst_cpu_resp_valid", cpu_resp_valid, 0);
    check("rst_cpu_resp_rdata", cpu_resp_rdata, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_write", mem_req_write, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_mem_req_wdata", mem_req_wdata, 0);
    for (int i = 0; i < NL; i++) check("rst_valid", dut.valid[i], 0);
    @(negedge clock);
    release_reset();

    // Cold miss, hit, store hit, then dirty eviction.
    do_req(1'b0, 10'd5, '0);
    check("valid1_fill", dut.valid[1], 1);
    check("tag1_fill", dut.tag[1], 0);
    check("dirty1_fill", dut.dirty[1], 0);
    do_req(1'b0, 10'd6, '0);
    do_req(1'b1, 10'd6, 32'h55);
    check("block1_2_store", dut.block[1][2], 32'h55);
    check("dirty1_store", dut.dirty[1], 1);
    check("mem6_before_wb", mem[6], 6);
    do_req(1'b0, 10'd22, '0);
    check("mem6_after_wb", mem[6], 32'h55);
    check("tag1_evict", dut.tag[1], 1);
    check("dirty1_evict", dut.dirty[1], 0);

    // Five-cycle back-pressure on refill beat 2.
    stall_arm = 1;
    do_req(1'b0, 10'd37, '0);

    // Reset while a refill beat is being offered under back-pressure.
    stall_arm = 1;
    @(negedge clock);
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 10'd42;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock); #1;
      cyc++;
    end while (!(mem_req_valid && !mem_req_ready) && cyc < 50);
    check("rfreq_stalled", mem_req_valid && !mem_req_ready, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_mem_req_valid", mem_req_valid, 0);
    check("rst_async_mem_req_addr", mem_req_addr, 0);
    check("rst_async_cpu_req_ready", cpu_req_ready, 0);
    release_reset();

    // Reset during RF_WAIT on a refill of address 5.
    do_req(1'b1, 10'd9, 32'hA5A5);
    @(negedge clock);
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 10'd5;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock); #1;
      cyc++;
    end while (!(mem_req_valid && mem_req_ready) && cyc < 50);
    check("rf_beat_offered", mem_req_valid && mem_req_ready, 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rfwait_rst_mem_req_valid", mem_req_valid, 0);
    check("rfwait_rst_cpu_resp_valid", cpu_resp_valid, 0);
    for (int i = 0; i < NL; i++) check("rfwait_rst_valid", dut.valid[i], 0);
    release_reset();
    do_req(1'b0, 10'd5, '0);
    do_req(1'b0, 10'd9, '0);

    // Random traffic over a small address window with random memory back-pressure.
    rand_ready = 1;
    for (int n = 0; n < 80; n++)
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
    rand_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
